// File: rtl/regfile_bist_pkg.sv
// Shared types and per-element constant tables for the register-file March BIST.
package regfile_bist_pkg;

    // March elements in execution order; the numeric values are reported on first_fail_elem.
    typedef enum logic [2:0] {
        M0  = 3'd0,
        M1  = 3'd1,
        M2  = 3'd2,
        M3  = 3'd3,
        M4  = 3'd4,
        M5  = 3'd5,
        X0W = 3'd6,
        X0R = 3'd7
    } elem_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Per-element tables, indexed by elem_t (bit n describes element n).
    // ELEM_DESC   : 1 = addresses walk downwards (DEPTH-1 .. 1)
    // ELEM_HAS_RD : element performs a read + compare
    // ELEM_HAS_WR : element performs a write
    // ELEM_RPOL   : expected read data is ~DB (else DB)
    // ELEM_WPOL   : write data is ~DB (else DB)
    localparam logic [7:0] ELEM_DESC   = 8'b0011_1000;
    localparam logic [7:0] ELEM_HAS_RD = 8'b1011_1110;
    localparam logic [7:0] ELEM_HAS_WR = 8'b0101_1111;
    localparam logic [7:0] ELEM_RPOL   = 8'b0001_0100;
    localparam logic [7:0] ELEM_WPOL   = 8'b0100_1010;

    // Element that follows e in the sequence.
    function automatic elem_t next_elem(elem_t e);
        return elem_t'(e + 3'd1);
    endfunction

endpackage

// File: rtl/regfile_march_bist_if.sv
// Register-file access bus between the BIST (master) and the register file (slave).
interface regfile_march_bist_if #(
    parameter int WIDTH = 32,
    parameter int ADDRW = 5
);
    logic             rf_we;
    logic [ADDRW-1:0] rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic [ADDRW-1:0] rf_raddr;
    logic [WIDTH-1:0] rf_rdata;

    modport master (
        output rf_we,
        output rf_waddr,
        output rf_wdata,
        output rf_raddr,
        input  rf_rdata
    );

    modport slave (
        input  rf_we,
        input  rf_waddr,
        input  rf_wdata,
        input  rf_raddr,
        output rf_rdata
    );
endinterface

// File: rtl/regfile_march_bist.sv
// March C- self-test controller for the register file: walks M0..M5 over
// addresses 1..DEPTH-1, then checks that x0 ignores writes and reads as zero.
// Counts mismatches and captures the first failing address/element/syndrome.
module regfile_march_bist
    import regfile_bist_pkg::*;
#(
    parameter int                 WIDTH      = 32,
    parameter int                 DEPTH      = 32,
    parameter int                 ADDRW      = $clog2(DEPTH),
    parameter logic [WIDTH-1:0]   BACKGROUND = '0,
    parameter int                 CNTW       = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [CNTW-1:0]              fail_count,
    output logic [ADDRW-1:0]             first_fail_addr,
    output logic [2:0]                   first_fail_elem,
    output logic [WIDTH-1:0]             first_fail_syn,
    regfile_march_bist_if.master         rf
);

    localparam logic [ADDRW-1:0] ADDR_LO = ADDRW'(1);
    localparam logic [ADDRW-1:0] ADDR_HI = ADDRW'(DEPTH - 1);

    state_t           state_q;
    elem_t            elem_q, elem_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic             last_op;

    logic             busy_q, done_q;
    logic [CNTW-1:0]  fail_count_q;
    logic [ADDRW-1:0] ff_addr_q;
    logic [2:0]       ff_elem_q;
    logic [WIDTH-1:0] ff_syn_q;

    logic             rf_we_q, rf_we_d;
    logic [ADDRW-1:0] rf_waddr_q, rf_waddr_d;
    logic [WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic [ADDRW-1:0] rf_raddr_q, rf_raddr_d;

    logic             accept;
    logic             op_valid;
    elem_t            op_elem;
    logic [ADDRW-1:0] op_addr;

    logic [WIDTH-1:0] expected;
    logic [WIDTH-1:0] syndrome;
    logic             mismatch;

    assign accept = (state_q != RUN) && start;

    // Sequencer: next (element, address) after the current op, and whether this is the last op.
    always_comb begin
        elem_d  = elem_q;
        addr_d  = addr_q;
        last_op = 1'b0;
        if (elem_q == X0R) begin
            last_op = 1'b1;
        end else if (elem_q == X0W) begin
            elem_d = X0R;
            addr_d = '0;
        end else if (ELEM_DESC[elem_q] ? (addr_q == ADDR_LO) : (addr_q == ADDR_HI)) begin
            elem_d = next_elem(elem_q);
            if (elem_d == X0W)
                addr_d = '0;
            else if (ELEM_DESC[elem_d])
                addr_d = ADDR_HI;
            else
                addr_d = ADDR_LO;
        end else begin
            addr_d = ELEM_DESC[elem_q] ? (addr_q - ADDRW'(1)) : (addr_q + ADDRW'(1));
        end
    end

    // Decode the op that occupies the next cycle into the bus values registered at this edge.
    always_comb begin
        op_valid = 1'b0;
        op_elem  = M0;
        op_addr  = ADDR_LO;
        if (accept) begin
            op_valid = 1'b1;
        end else if (state_q == RUN && !last_op) begin
            op_valid = 1'b1;
            op_elem  = elem_d;
            op_addr  = addr_d;
        end
        rf_we_d    = op_valid && ELEM_HAS_WR[op_elem];
        rf_waddr_d = rf_we_d ? op_addr : '0;
        rf_wdata_d = '0;
        if (rf_we_d)
            rf_wdata_d = ELEM_WPOL[op_elem] ? ~BACKGROUND : BACKGROUND;
        rf_raddr_d = (op_valid && ELEM_HAS_RD[op_elem]) ? op_addr : '0;
    end

    // Compare the read port against the element's expected value (x0 must always read zero).
    always_comb begin
        if (elem_q == X0R)
            expected = '0;
        else
            expected = ELEM_RPOL[elem_q] ? ~BACKGROUND : BACKGROUND;
        syndrome = rf.rf_rdata ^ expected;
        mismatch = (state_q == RUN) && ELEM_HAS_RD[elem_q] && (syndrome != '0);
    end

    // Controller FSM with registered bus outputs, status and failure capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            elem_q       <= M0;
            addr_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_count_q <= '0;
            ff_addr_q    <= '0;
            ff_elem_q    <= '0;
            ff_syn_q     <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            rf_raddr_q   <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            rf_raddr_q <= rf_raddr_d;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q      <= RUN;
                        elem_q       <= M0;
                        addr_q       <= ADDR_LO;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        fail_count_q <= '0;
                        ff_addr_q    <= '0;
                        ff_elem_q    <= '0;
                        ff_syn_q     <= '0;
                    end
                end
                RUN: begin
                    if (mismatch) begin
                        if (fail_count_q != '1)
                            fail_count_q <= fail_count_q + CNTW'(1);
                        if (fail_count_q == '0) begin
                            ff_addr_q <= addr_q;
                            ff_elem_q <= elem_q;
                            ff_syn_q  <= syndrome;
                        end
                    end
                    if (last_op) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        elem_q <= elem_d;
                        addr_q <= addr_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = done_q && (fail_count_q == '0);
    assign fail_count      = fail_count_q;
    assign first_fail_addr = ff_addr_q;
    assign first_fail_elem = ff_elem_q;
    assign first_fail_syn  = ff_syn_q;

    assign rf.rf_we    = rf_we_q;
    assign rf.rf_waddr = rf_waddr_q;
    assign rf.rf_wdata = rf_wdata_q;
    assign rf.rf_raddr = rf_raddr_q;

endmodule

// File: tb/tb_regfile_march_bist.sv
// Bench for regfile_march_bist: a behavioural register file with x0 hardwired to
// zero and a read-side fault injector sits on the bus; fault scenarios are table driven.
module tb_regfile_march_bist;
    import regfile_bist_pkg::*;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 32;
    localparam int ADDRW  = 5;
    localparam int CNTW   = 8;
    localparam int OPS    = 6 * (DEPTH - 1) + 2;
    localparam int BOUND  = 1000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             busy, done, pass;
    logic [CNTW-1:0]  fail_count;
    logic [ADDRW-1:0] first_fail_addr;
    logic [2:0]       first_fail_elem;
    logic [WIDTH-1:0] first_fail_syn;

    // fault types: 0 stuck-at-1, 1 stuck-at-0, 2 bit-flip
    logic             fault_enable = 1'b0;
    logic [1:0]       fault_type   = 2'd0;
    logic [ADDRW-1:0] fault_addr   = '0;
    logic [WIDTH-1:0] fault_mask   = '0;

    int total = 0;
    int bad   = 0;

    regfile_march_bist_if #(.WIDTH(WIDTH), .ADDRW(ADDRW)) rf_bus ();

    regfile_march_bist #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDRW(ADDRW), .BACKGROUND('0), .CNTW(CNTW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .fail_count      (fail_count),
        .first_fail_addr (first_fail_addr),
        .first_fail_elem (first_fail_elem),
        .first_fail_syn  (first_fail_syn),
        .rf              (rf_bus.master)
    );

    always #5 clk = ~clk;

    // Register file model: x0 ignores writes and reads zero; faults act on the read path.
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (rf_bus.rf_we && rf_bus.rf_waddr != '0)
            mem[rf_bus.rf_waddr] <= rf_bus.rf_wdata;
    end

    always_comb begin
        logic [WIDTH-1:0] raw;
        raw = (rf_bus.rf_raddr == '0) ? '0 : mem[rf_bus.rf_raddr];
        if (fault_enable && rf_bus.rf_raddr == fault_addr && rf_bus.rf_raddr != '0) begin
            case (fault_type)
                2'd0:    raw = raw | fault_mask;
                2'd1:    raw = raw & ~fault_mask;
                default: raw = raw ^ fault_mask;
            endcase
        end
        rf_bus.rf_rdata = raw;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulse start for one cycle, then count busy cycles until it drops (bounded).
    task automatic run_once(output int busy_cycles);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cycles = 0;
        while (busy && busy_cycles < BOUND) begin
            busy_cycles++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        string       name;
        logic        fen;
        logic [1:0]  ftype;
        logic [4:0]  faddr;
        logic [31:0] fmask;
        logic [7:0]  exp_count;
        logic [2:0]  exp_elem;
        logic [4:0]  exp_addr;
        logic [31:0] exp_syn;
        logic        exp_pass;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int n;

        vecs[0] = '{"fault_free", 1'b0, 2'd0, 5'd0,  32'h0,          8'd0, 3'd0, 5'd0,  32'h0,          1'b1};
        vecs[1] = '{"sa1_a5_b0",  1'b1, 2'd0, 5'd5,  32'h0000_0001,  8'd3, 3'd1, 5'd5,  32'h0000_0001,  1'b0};
        vecs[2] = '{"sa0_a31_b31",1'b1, 2'd1, 5'd31, 32'h8000_0000,  8'd2, 3'd2, 5'd31, 32'h8000_0000,  1'b0};
        vecs[3] = '{"flip_a1",    1'b1, 2'd2, 5'd1,  32'hFFFF_FFFF,  8'd5, 3'd1, 5'd1,  32'hFFFF_FFFF,  1'b0};
        vecs[4] = '{"sa1_a31_b31",1'b1, 2'd0, 5'd31, 32'h8000_0000,  8'd3, 3'd1, 5'd31, 32'h8000_0000,  1'b0};
        vecs[5] = '{"sa0_a1_b0",  1'b1, 2'd1, 5'd1,  32'h0000_0001,  8'd2, 3'd2, 5'd1,  32'h0000_0001,  1'b0};
        vecs[6] = '{"flip_a0",    1'b1, 2'd2, 5'd0,  32'hFFFF_FFFF,  8'd0, 3'd0, 5'd0,  32'h0,          1'b1};

        // Reset state
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pass", 64'(pass), 64'd0);
        check("rst_count", 64'(fail_count), 64'd0);
        check("rst_we", 64'(rf_bus.rf_we), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven fault scenarios
        for (int i = 0; i < 7; i++) begin
            fault_enable = vecs[i].fen;
            fault_type   = vecs[i].ftype;
            fault_addr   = vecs[i].faddr;
            fault_mask   = vecs[i].fmask;
            run_once(n);
            check({vecs[i].name, "_busy_cycles"}, 64'(n), 64'(OPS));
            check({vecs[i].name, "_done"}, 64'(done), 64'd1);
            check({vecs[i].name, "_pass"}, 64'(pass), 64'(vecs[i].exp_pass));
            check({vecs[i].name, "_count"}, 64'(fail_count), 64'(vecs[i].exp_count));
            check({vecs[i].name, "_elem"}, 64'(first_fail_elem), 64'(vecs[i].exp_elem));
            check({vecs[i].name, "_addr"}, 64'(first_fail_addr), 64'(vecs[i].exp_addr));
            check({vecs[i].name, "_syn"}, 64'(first_fail_syn), 64'(vecs[i].exp_syn));
            $display("vec %0d %s: cycles=%0d count=%0d elem=%0d addr=%0d syn=0x%08h pass=%0b",
                     i, vecs[i].name, n, fail_count, first_fail_elem, first_fail_addr,
                     first_fail_syn, pass);
        end
        fault_enable = 1'b0;

        // Bus timing of first op and a mid-run op, then asynchronous reset at op cycle 50
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("op1_we", 64'(rf_bus.rf_we), 64'd1);
        check("op1_waddr", 64'(rf_bus.rf_waddr), 64'd1);
        check("op1_wdata", 64'(rf_bus.rf_wdata), 64'd0);
        check("op1_raddr", 64'(rf_bus.rf_raddr), 64'd0);
        check("op1_done_cleared", 64'(done), 64'd0);
        repeat (49) @(negedge clk);
        check("op50_we", 64'(rf_bus.rf_we), 64'd1);
        check("op50_raddr", 64'(rf_bus.rf_raddr), 64'd19);
        check("op50_waddr", 64'(rf_bus.rf_waddr), 64'd19);
        check("op50_wdata", 64'(rf_bus.rf_wdata), 64'hFFFF_FFFF);
        #2 rst = 1'b1;
        #1;
        check("async_rst_we", 64'(rf_bus.rf_we), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_count", 64'(fail_count), 64'd0);
        $display("reset mid-run: we=%0b busy=%0b", rf_bus.rf_we, busy);
        @(negedge clk);
        rst = 1'b0;
        run_once(n);
        check("post_rst_cycles", 64'(n), 64'(OPS));
        check("post_rst_pass", 64'(pass), 64'd1);
        $display("run after reset: cycles=%0d pass=%0b", n, pass);

        // start held high: no restart while busy, rerun after done clears results
        fault_enable = 1'b1;
        fault_type   = 2'd0;
        fault_addr   = 5'd5;
        fault_mask   = 32'h1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        n = 0;
        while (busy && n < BOUND) begin
            n++;
            @(negedge clk);
        end
        check("held_cycles", 64'(n), 64'(OPS));
        check("held_done", 64'(done), 64'd1);
        check("held_count", 64'(fail_count), 64'd3);
        fault_addr = 5'd0;
        @(negedge clk);
        check("rerun_busy", 64'(busy), 64'd1);
        check("rerun_done_cleared", 64'(done), 64'd0);
        check("rerun_count_cleared", 64'(fail_count), 64'd0);
        start = 1'b0;
        n = 1;
        @(negedge clk);
        while (busy && n < BOUND) begin
            n++;
            @(negedge clk);
        end
        check("rerun_cycles", 64'(n), 64'(OPS));
        check("rerun_pass", 64'(pass), 64'd1);
        check("rerun_count", 64'(fail_count), 64'd0);
        $display("held-start rerun: cycles=%0d pass=%0b count=%0d", n, pass, fail_count);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
